// File: rtl/vram_arb_pkg.sv
// Shared types and default sizes for the VRAM slot arbiter.
package vram_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } host_st_t;

  typedef enum logic {
    SLOT_VID  = 1'b0,
    SLOT_HOST = 1'b1
  } slot_t;

endpackage

// File: rtl/vram_slot_timer.sv
// Pixel-phase generator: divides clk by two and decides which side owns
// the RAM in the current clk.
module vram_slot_timer
  import vram_arb_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_reset,
  input  logic  i_display_on,
  output logic  o_phase,
  output slot_t o_slot
);

  logic r_phase;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_phase <= 1'b0;
    else         r_phase <= ~r_phase;
  end

  assign o_phase = r_phase;
  // Phase 0 belongs to video only while the display is active.
  assign o_slot  = (!r_phase && i_display_on) ? SLOT_VID : SLOT_HOST;

endmodule

// File: rtl/vram_slot_arbiter.sv
// Shares one single-port video RAM between scanout and a host port using
// fixed time slots; video reads are never delayed.
module vram_slot_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  output logic              pix_ce,
  input  logic              display_on,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_valid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  slot_t               w_slot;
  logic                w_phase;
  logic                w_vid_issue;
  logic                w_host_issue;
  host_st_t            r_state;
  logic                r_rd;
  logic                r_vid_valid;
  logic [DATA_W-1:0]   r_vid_rdata;
  logic [DATA_W-1:0]   r_host_rdata;

  vram_slot_timer u_timer (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_display_on (display_on),
    .o_phase      (w_phase),
    .o_slot       (w_slot)
  );

  assign pix_ce       = w_phase;
  assign w_vid_issue  = !reset && (w_slot == SLOT_VID);
  assign w_host_issue = !reset && (w_slot == SLOT_HOST) && (r_state == ST_IDLE) && host_req;

  always_comb begin
    mem_addr  = host_addr;
    mem_wdata = host_wdata;
    mem_we    = 1'b0;
    if (w_slot == SLOT_VID) mem_addr = vid_addr;
    else if (w_host_issue)  mem_we   = host_we;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_rd         <= 1'b0;
      r_vid_valid  <= 1'b0;
      r_vid_rdata  <= '0;
      r_host_rdata <= '0;
    end else begin
      r_vid_valid <= w_vid_issue;
      if (r_vid_valid) r_vid_rdata <= mem_rdata;
      case (r_state)
        ST_IDLE: begin
          if (w_host_issue) begin
            r_state <= ST_RESP;
            r_rd    <= !host_we;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          if (r_rd) r_host_rdata <= mem_rdata;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // RAM data is forwarded in the return clk so it is valid alongside the
  // strobe, then held by the capture register.
  assign vid_valid  = r_vid_valid;
  assign vid_rdata  = r_vid_valid ? mem_rdata : r_vid_rdata;
  assign host_ack   = (r_state == ST_RESP);
  assign host_rdata = (host_ack && r_rd) ? mem_rdata : r_host_rdata;

endmodule

// File: tb/tb_vram_slot_arbiter.sv
// Self-checking bench for vram_slot_arbiter with a behavioural RAM and
// slot-rule reference model.
module tb_vram_slot_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pix_ce;
  logic          display_on = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [DW-1:0] vid_rdata;
  logic          vid_valid;
  logic          host_req = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic          host_ack;
  logic [DW-1:0] host_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  vram_slot_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_ce     (pix_ce),
    .display_on (display_on),
    .vid_addr   (vid_addr),
    .vid_rdata  (vid_rdata),
    .vid_valid  (vid_valid),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Synchronous single-port RAM, one clk read latency.
  logic [DW-1:0] ram [0:65535];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hB5;
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pixel phase, and the pixel fetched in the previous clk.
  bit            exp_phase = 1'b0;
  bit            m_vid_pend = 1'b0;
  logic [15:0]   m_vid_pa = '0;
  logic [7:0]    m_vid_last = '0;
  logic [7:0]    last_rd = '0;
  logic [7:0]    shadow [0:255];
  bit            mon_en = 1'b0;
  bit            disp_rand = 1'b0;
  bit            force10 = 1'b0;

  always @(posedge clk) begin
    exp_phase <= reset ? 1'b0 : !exp_phase;
    if (reset) begin
      m_vid_pend <= 1'b0;
      m_vid_last <= '0;
    end else begin
      if (m_vid_pend) m_vid_last <= pat(m_vid_pa);
      m_vid_pend <= !exp_phase && display_on;
      m_vid_pa   <= vid_addr;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("pix_ce", 32'(pix_ce), 32'(exp_phase));
      chk("vid_valid", 32'(vid_valid), 32'(m_vid_pend));
      chk("vid_rdata", 32'(vid_rdata), 32'(m_vid_pend ? pat(m_vid_pa) : m_vid_last));
      if (reset) chk("mem_we_rst", 32'(mem_we), 32'd0);
      else if (!exp_phase && display_on) begin
        chk("vid_mem_addr", 32'(mem_addr), 32'(vid_addr));
        chk("vid_mem_we", 32'(mem_we), 32'd0);
      end
    end
  end

  // Scanout address and display_on stimulus; display_on moves only at pixel starts.
  always @(posedge clk) begin
    #2;
    vid_addr = force10 ? 16'h0010 : 16'($urandom_range(0, 255));
    if (disp_rand && !exp_phase && $urandom_range(0, 5) == 0) display_on = !display_on;
  end

  task automatic host_xfer(input bit we, input logic [15:0] addr, input logic [7:0] wd, input bit align0);
    int n;
    int expn;
    bit acked;
    @(posedge clk); #1;
    while (align0 && exp_phase) begin
      @(posedge clk); #1;
    end
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
    n = 0; expn = 2; acked = 1'b0;
    while (!acked && n < 8) begin
      @(negedge clk);
      n++;
      // A request landing on a video slot waits one clk for the host slot.
      if (n == 1) expn = (!exp_phase && display_on) ? 3 : 2;
      if (n == expn - 1) begin
        chk("issue_we", 32'(mem_we), 32'(we));
        chk("issue_addr", 32'(mem_addr), 32'(addr));
        if (we) chk("issue_wdata", 32'(mem_wdata), 32'(wd));
      end
      if (host_ack) acked = 1'b1;
    end
    chk("ack_latency", 32'(n), 32'(expn));
    if (acked && !we) begin
      chk("host_rdata", 32'(host_rdata), 32'(shadow[addr[7:0]]));
      last_rd = shadow[addr[7:0]];
    end
    if (acked && we) shadow[addr[7:0]] = wd;
  endtask

  task automatic host_idle(input int cyc);
    @(posedge clk); #1;
    host_req = 1'b0;
    repeat (cyc) begin
      @(negedge clk);
      chk("ack_idle", 32'(host_ack), 32'd0);
      chk("rdata_hold", 32'(host_rdata), 32'(last_rd));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = pat(i[15:0]);
    for (int i = 0; i < 256; i++) shadow[i] = pat(16'h0200 | 16'(i));

    repeat (3) begin
      @(negedge clk);
      chk("rst_pix_ce", 32'(pix_ce), 32'd0);
      chk("rst_vid_valid", 32'(vid_valid), 32'd0);
      chk("rst_vid_rdata", 32'(vid_rdata), 32'd0);
      chk("rst_host_ack", 32'(host_ack), 32'd0);
      chk("rst_host_rdata", 32'(host_rdata), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("pix_seq", 32'(pix_ce), 32'(i % 2));
    end

    // Scanout fetch of a known pixel.
    @(posedge clk); #1;
    force10 = 1'b1;
    display_on = 1'b1;
    begin
      int k;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (exp_phase && k < 4);
    end
    chk("vid_fetch_addr", 32'(mem_addr), 32'h0010);
    @(negedge clk);
    chk("vid_fetch_valid", 32'(vid_valid), 32'd1);
    chk("vid_fetch_data", 32'(vid_rdata), 32'hA5);
    @(negedge clk);
    chk("vid_fetch_pulse", 32'(vid_valid), 32'd0);
    chk("vid_fetch_hold", 32'(vid_rdata), 32'hA5);
    force10 = 1'b0;

    // Host write during active display, raised on a video slot.
    host_xfer(1'b1, 16'h0200, 8'h3C, 1'b1);
    host_idle(2);

    // Blanking: read back, then a held request for back-to-back reads.
    @(posedge clk); #1;
    display_on = 1'b0;
    host_xfer(1'b0, 16'h0200, 8'h00, 1'b0);
    chk("wr_rd_data", 32'(host_rdata), 32'h3C);
    host_xfer(1'b0, 16'h0201, 8'h00, 1'b0);
    host_xfer(1'b1, 16'h0202, 8'h77, 1'b0);
    host_xfer(1'b0, 16'h0202, 8'h00, 1'b0);
    host_idle(2);

    // Randomized traffic with display_on toggling underneath.
    disp_rand = 1'b1;
    for (int t = 0; t < 200; t++) begin
      host_xfer(1'(($urandom_range(0, 1))), {8'h02, 8'($urandom_range(0, 255))},
                8'($urandom_range(0, 255)), 1'b0);
      if ($urandom_range(0, 2) == 0) host_idle(int'($urandom_range(1, 3)));
    end
    host_idle(1);
    disp_rand = 1'b0;

    // Reset asserted in the issue cycle of a host read drops it.
    @(posedge clk); #1;
    display_on = 1'b0;
    @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0200; reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_drop_ack", 32'(host_ack), 32'd0);
    end
    chk("rst_drop_rdata", 32'(host_rdata), 32'd0);
    @(posedge clk); #1;
    host_req = 1'b0; reset = 1'b0; last_rd = '0;
    @(negedge clk);
    chk("rst_after_ack", 32'(host_ack), 32'd0);
    host_xfer(1'b0, 16'h0200, 8'h00, 1'b0);
    chk("reissue_data", 32'(host_rdata), 32'h3C);
    host_idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
